// File: rtl/dmem_if.sv
// dmem_if: load/store request channel and response channel between a
// MEM-stage requester and the data-memory responder.
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_funct3           RV64 size/sign code (instruction funct3 encoding)
//   req_addr             byte address
//   req_wdata            store data, low bytes used for SB/SH/SW
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            extended load result, 0 for stores and errors
//   rsp_err              misaligned, out-of-range or illegal funct3
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the MEM stage.
// Accepts one load/store at a time, answers after LATENCY cycles with RV64
// size/sign handling and an error flag for bad accesses.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high; aborts any in-flight request
//   bus    dmem_if slave side (request and response handshakes)
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic   clk,
   input  logic   reset,
   dmem_if.slave  bus
);

   localparam int AW    = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             rsp_valid_r;
   logic [63:0]      rsp_rdata_r;
   logic             rsp_err_r;

   logic             cap_we;
   logic [2:0]       cap_funct3;
   logic [63:0]      cap_addr;
   logic [63:0]      cap_wdata;

   logic [63:0]      mem [DEPTH_WORDS];

   logic             accept;
   logic             do_access;
   logic             a_we;
   logic [2:0]       a_funct3;
   logic [63:0]      a_addr;
   logic [63:0]      a_wdata;
   logic [AW-1:0]    a_idx;
   logic [2:0]       a_off;
   logic             a_err;
   logic [63:0]      a_rdata;
   logic [63:0]      rd_shift;
   logic [7:0]       be;
   logic [63:0]      wdata_sh;

   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   return 8'h01;
         2'b01:   return 8'h03;
         2'b10:   return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic access_err(input logic we, input logic [2:0] f3,
                                       input logic [63:0] addr);
      logic illegal;
      logic misaligned;
      illegal = we ? f3[2] : (f3 == 3'b111);
      case (f3[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = addr[0];
         2'b10:   misaligned = |addr[1:0];
         default: misaligned = |addr[2:0];
      endcase
      return illegal || misaligned || (|addr[63:AW+3]);
   endfunction

   function automatic logic [63:0] load_extend(input logic [63:0] s, input logic [2:0] f3);
      case (f3)
         3'b000:  return {{56{s[7]}},  s[7:0]};
         3'b001:  return {{48{s[15]}}, s[15:0]};
         3'b010:  return {{32{s[31]}}, s[31:0]};
         3'b011:  return s;
         3'b100:  return {56'd0, s[7:0]};
         3'b101:  return {48'd0, s[15:0]};
         3'b110:  return {32'd0, s[31:0]};
         default: return 64'd0;
      endcase
   endfunction

   assign bus.req_ready = (state == IDLE) && !reset;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_err   = rsp_err_r;

   assign accept = bus.req_valid && bus.req_ready;

   // With LATENCY==1 the access happens on the accept edge, so the live
   // request fields are used; otherwise the captured copy is used.
   always_comb begin
      a_we      = cap_we;
      a_funct3  = cap_funct3;
      a_addr    = cap_addr;
      a_wdata   = cap_wdata;
      if (state == IDLE) begin
         a_we     = bus.req_we;
         a_funct3 = bus.req_funct3;
         a_addr   = bus.req_addr;
         a_wdata  = bus.req_wdata;
      end
   end

   assign do_access = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == '0));

   assign a_idx    = a_addr[3 +: AW];
   assign a_off    = a_addr[2:0];
   assign a_err    = access_err(a_we, a_funct3, a_addr);
   assign rd_shift = mem[a_idx] >> {a_off, 3'b000};
   assign a_rdata  = (a_err || a_we) ? 64'd0 : load_extend(rd_shift, a_funct3);
   assign be       = size_mask(a_funct3[1:0]) << a_off;
   assign wdata_sh = a_wdata << {a_off, 3'b000};

   // Request capture: data only, no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         cap_we     <= bus.req_we;
         cap_funct3 <= bus.req_funct3;
         cap_addr   <= bus.req_addr;
         cap_wdata  <= bus.req_wdata;
      end
   end

   // Store commit: byte-enabled write on the edge the response is produced.
   always_ff @(posedge clk) begin
      if (do_access && a_we && !a_err) begin
         for (int b = 0; b < 8; b++) begin
            if (be[b]) mem[a_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 64'd0;
         rsp_err_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt <= CNT_W'(LATENCY - 1);
                  if (LATENCY == 1) begin
                     state       <= RESP;
                     rsp_valid_r <= 1'b1;
                     rsp_rdata_r <= a_rdata;
                     rsp_err_r   <= a_err;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state       <= RESP;
                  rsp_valid_r <= 1'b1;
                  rsp_rdata_r <= a_rdata;
                  rsp_err_r   <= a_err;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state       <= IDLE;
                  rsp_valid_r <= 1'b0;
                  rsp_rdata_r <= 64'd0;
                  rsp_err_r   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed bench for dmem_responder,
// compared against a byte-array reference memory model.
module tb_dmem_responder;
   localparam int DEPTH = 64;
   localparam int LAT   = 3;
   localparam int BYTES = 8 * DEPTH;

   logic clk = 1'b0;
   logic reset;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   logic [7:0] ref_mem [BYTES];

   dmem_if bus();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got !== exp)
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      else
         pass_cnt++;
   endtask

   // Reference: plain byte-level semantics of RV64 loads/stores.
   task automatic model(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, output logic [63:0] rd, output logic err);
      int  size;
      logic illegal;
      size    = 1 << f3[1:0];
      illegal = we ? f3[2] : (f3 == 3'b111);
      err     = illegal || ((addr % size) != 0) || (addr >= BYTES);
      rd      = 64'd0;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < size; i++) rd[8*i +: 8] = ref_mem[int'(addr) + i];
            if (!f3[2] && size < 8 && rd[8*size-1])
               for (int i = size; i < 8; i++) rd[8*i +: 8] = 8'hFF;
         end
      end
   endtask

   // One full transaction with latency, data and return-to-idle checks.
   task automatic txn(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] wd, output logic [63:0] got_rd, output logic got_err);
      int n;
      logic [63:0] exp_rd;
      logic exp_err;
      got_rd  = 64'd0;
      got_err = 1'b0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      bus.rsp_ready  = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         check_val("accept_timeout", 64'(bus.req_ready), 64'd1);
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'($urandom);
      bus.req_funct3 = 3'($urandom);
      bus.req_addr   = {$urandom, $urandom};
      bus.req_wdata  = {$urandom, $urandom};
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("latency", 64'(n), 64'(LAT));
      model(we, f3, addr, wd, exp_rd, exp_err);
      got_rd  = bus.rsp_rdata;
      got_err = bus.rsp_err;
      check_val("rdata", got_rd, exp_rd);
      check_val("err", 64'(got_err), 64'(exp_err));
      @(posedge clk);
      #1;
      check_val("rsp_drop", 64'(bus.rsp_valid), 64'd0);
      check_val("back_idle", 64'(bus.req_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] rd, held, exp_rd;
      logic        er, exp_err;
      logic [2:0]  f3;
      logic [63:0] addr;
      int          hi;
      int          r;

      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 64'd0;
      bus.req_wdata  = 64'd0;
      bus.rsp_ready  = 1'b1;
      reset = 1'b1;
      #12;
      check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check_val("rst_rdata", bus.rsp_rdata, 64'd0);
      check_val("rst_err", 64'(bus.rsp_err), 64'd0);
      check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_val("post_rst_ready", 64'(bus.req_ready), 64'd1);

      // Fill every word so loads never see uninitialised memory.
      for (int w = 0; w < DEPTH; w++)
         txn(1'b1, 3'b011, 64'(8*w), {$urandom, $urandom}, rd, er);

      // Directed: doubleword round trip, then byte store and extensions.
      txn(1'b1, 3'b011, 64'h10, 64'h1122334455667788, rd, er);
      txn(1'b0, 3'b011, 64'h10, 64'd0, rd, er);
      check_val("t1_ld", rd, 64'h1122334455667788);
      txn(1'b1, 3'b000, 64'h13, 64'h80, rd, er);
      txn(1'b0, 3'b000, 64'h13, 64'd0, rd, er);
      check_val("t2_lb", rd, 64'hFFFFFFFFFFFFFF80);
      txn(1'b0, 3'b100, 64'h13, 64'd0, rd, er);
      check_val("t2_lbu", rd, 64'h80);
      txn(1'b0, 3'b011, 64'h10, 64'd0, rd, er);
      check_val("t2_ld", rd, 64'h1122334480667788);

      // Misaligned word accesses must not write.
      txn(1'b0, 3'b010, 64'h12, 64'd0, rd, er);
      check_val("t3_lw_err", 64'(er), 64'd1);
      txn(1'b1, 3'b010, 64'h12, 64'hCAFEBABE, rd, er);
      check_val("t3_sw_err", 64'(er), 64'd1);
      txn(1'b0, 3'b011, 64'h10, 64'd0, rd, er);
      check_val("t3_ld", rd, 64'h1122334480667788);

      // Backpressure: response held while a competing store waits on req.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b011;
      bus.req_addr   = 64'h10;
      bus.rsp_ready  = 1'b0;
      @(posedge clk);
      #1;
      bus.req_we     = 1'b1;
      bus.req_addr   = 64'h30;
      bus.req_wdata  = 64'hDEADBEEFDEADBEEF;
      r = 0;
      while (!bus.rsp_valid && r < 20) begin
         @(posedge clk);
         #1;
         r++;
      end
      check_val("bp_latency", 64'(r), 64'(LAT));
      model(1'b0, 3'b011, 64'h10, 64'd0, exp_rd, exp_err);
      held = bus.rsp_rdata;
      check_val("bp_rdata", held, exp_rd);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_val("bp_valid_hold", 64'(bus.rsp_valid), 64'd1);
         check_val("bp_rdata_hold", bus.rsp_rdata, held);
         check_val("bp_req_ready", 64'(bus.req_ready), 64'd0);
      end
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check_val("bp_released", 64'(bus.rsp_valid), 64'd0);
      check_val("bp_idle", 64'(bus.req_ready), 64'd1);
      txn(1'b0, 3'b011, 64'h30, 64'd0, rd, er);

      // Reset during WAIT drops the store and its response.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'b011;
      bus.req_addr   = 64'h20;
      bus.req_wdata  = 64'hAA;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_val("mid_rst_ready", 64'(bus.req_ready), 64'd0);
      check_val("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      hi = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) hi++;
      end
      check_val("abort_no_rsp", 64'(hi), 64'd0);
      txn(1'b0, 3'b011, 64'h20, 64'd0, rd, er);

      // Range and illegal-funct3 errors.
      txn(1'b0, 3'b011, 64'(BYTES), 64'd0, rd, er);
      check_val("t6_oor", 64'(er), 64'd1);
      txn(1'b0, 3'b111, 64'h18, 64'd0, rd, er);
      check_val("t6_f3_111", 64'(er), 64'd1);
      txn(1'b1, 3'b100, 64'h18, 64'h5555, rd, er);
      check_val("t6_sd_100", 64'(er), 64'd1);
      txn(1'b0, 3'b011, 64'h18, 64'd0, rd, er);

      // Randomized mix of loads and stores.
      for (int k = 0; k < 150; k++) begin
         f3 = 3'($urandom);
         r  = int'($urandom % 10);
         if (r == 0)
            addr = {$urandom, $urandom};
         else if (r < 3)
            addr = 64'($urandom % BYTES);
         else
            addr = 64'($urandom % BYTES) & ~64'((1 << f3[1:0]) - 1);
         txn(1'($urandom), f3, addr, {$urandom, $urandom}, rd, er);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
